// File: rtl/btn_sense_pkg.sv
// Shared types for the button sense / codec-fix sequencer and the boot selector.
package btn_sense_pkg;

  typedef enum logic [1:0] {
    ST_BOOT_DLY = 2'd0,
    ST_GO       = 2'd1,
    ST_WAIT_FIX = 2'd2,
    ST_ACTIVE   = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    EVT_NONE  = 2'd0,
    EVT_SHORT = 2'd1,
    EVT_LONG  = 2'd2
  } btn_evt_e;

endpackage

// File: rtl/btn_debounce.sv
// Counting debouncer: the level flips after 2^DEB_W consecutive sampled mismatches.
module btn_debounce #(
  parameter int DEB_W = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en_i,
  input  logic p_i,
  output logic pressed_o
);

  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic             pressed_q, pressed_d;

  always_comb begin
    cnt_d     = cnt_q;
    pressed_d = pressed_q;
    // Unsampled cycles leave both the count and the level untouched.
    if (sample_en_i) begin
      if (p_i != pressed_q) begin
        if (&cnt_q) begin
          pressed_d = p_i;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      pressed_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
    end
  end

  assign pressed_o = pressed_q;

endmodule

// File: rtl/btn_sense.sv
// Codec-fix sequencer plus debounced short/long press event generation.
module btn_sense
  import btn_sense_pkg::*;
#(
  parameter int BOOT_DLY_W = 16,
  parameter int DEB_W      = 10,
  parameter int LONG_W     = 22,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic fix_go,
  input  logic fix_rdy,
  input  logic fix_req,
  output logic btn_pressed,
  output logic evt_short,
  output logic evt_long,
  output logic busy
);

  localparam logic [LONG_W-1:0] HOLD_MAX = '1;

  seq_state_e              state_q, state_d;
  logic [BOOT_DLY_W-1:0]   dly_q, dly_d;
  logic                    entered_q;
  logic                    req_q;
  logic                    busy_q;
  logic                    pressed_d1_q;
  logic [LONG_W-1:0]       hold_q, hold_d;
  logic                    evt_short_q, evt_long_q;
  logic                    sample_en;
  logic                    press_rise, press_fall;
  logic                    long_hit, short_hit;

  assign sample_en = (state_q == ST_ACTIVE) && fix_rdy;

  btn_debounce #(
    .DEB_W(DEB_W)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .sample_en_i(sample_en),
    .p_i        (btn_raw ^ ACTIVE_LOW),
    .pressed_o  (btn_pressed)
  );

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    fix_go  = 1'b0;
    case (state_q)
      ST_BOOT_DLY: begin
        dly_d = dly_q + 1'b1;
        if (&dly_q) state_d = ST_GO;
      end
      ST_GO: begin
        if (fix_rdy) begin
          fix_go  = 1'b1;
          state_d = ST_WAIT_FIX;
        end
      end
      // entered_q masks the entry cycle, when codec_fix may still show ready.
      ST_WAIT_FIX: begin
        if (!entered_q && fix_rdy) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (req_q && fix_rdy) state_d = ST_GO;
      end
      default: state_d = ST_BOOT_DLY;
    endcase
  end

  assign press_rise = btn_pressed && !pressed_d1_q;
  assign press_fall = !btn_pressed && pressed_d1_q;

  always_comb begin
    hold_d   = hold_q;
    long_hit = 1'b0;
    if (press_rise) begin
      hold_d = '0;
    end else if (btn_pressed && (hold_q != HOLD_MAX)) begin
      hold_d   = hold_q + 1'b1;
      long_hit = (hold_q == HOLD_MAX - 1'b1);
    end
  end

  assign short_hit = press_fall && (hold_q != HOLD_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BOOT_DLY;
      dly_q        <= '0;
      entered_q    <= 1'b0;
      req_q        <= 1'b0;
      busy_q       <= 1'b1;
      pressed_d1_q <= 1'b0;
      hold_q       <= '0;
      evt_short_q  <= 1'b0;
      evt_long_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dly_q        <= dly_d;
      entered_q    <= fix_go;
      // A request coinciding with fix_go survives, queueing another run.
      req_q        <= fix_req || (req_q && !fix_go);
      busy_q       <= (state_d != ST_ACTIVE);
      pressed_d1_q <= btn_pressed;
      hold_q       <= hold_d;
      evt_short_q  <= short_hit;
      evt_long_q   <= long_hit;
    end
  end

  assign busy      = busy_q;
  assign evt_short = evt_short_q;
  assign evt_long  = evt_long_q;

endmodule
